// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-style control FSM with a memory-handshake timeout.
// Define MCU_BNE_EN to add the bne instruction (opcode 000101).
module multicycle_control_unit #(
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           Opcode,
  input  logic [5:0]           Funct,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 ALUSrcA,
  output logic                 Branch,
  output logic                 PCWrite,
  output logic                 PCEn,
  output logic                 illegal_op,
  output logic                 mem_err,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           PCSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemadr = 4'd2,
    StMemrd  = 4'd3,
    StMemwb  = 4'd4,
    StMemwr  = 4'd5,
    StExec   = 4'd6,
    StAluwb  = 4'd7,
    StBeq    = 4'd8,
    StAddiex = 4'd9,
    StAddiwb = 4'd10,
    StJump   = 4'd11,
    StBne    = 4'd12
  } state_e;

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpJ    = 6'b000010;
`ifdef MCU_BNE_EN
  localparam logic [5:0] OpBne  = 6'b000101;
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wait_st, timeout;
  state_e          dec_next;
  logic            op_legal;
  logic [2:0]      fn_alu;
  logic            fn_legal;
  logic [2:0]      aluc;
  logic            take_br;

  assign state   = state_q;
  assign wait_st = (state_q == StFetch) || (state_q == StMemrd) || (state_q == StMemwr);
  // mem_ready in the final allowed cycle still counts as a normal completion
  assign timeout = wait_st && !mem_ready && (cnt_q == CntMax);

  always_comb begin
    op_legal = 1'b1;
    dec_next = StFetch;
    case (Opcode)
      OpLw, OpSw: dec_next = StMemadr;
      OpR:        dec_next = StExec;
      OpBeq:      dec_next = StBeq;
      OpAddi:     dec_next = StAddiex;
      OpJ:        dec_next = StJump;
`ifdef MCU_BNE_EN
      OpBne:      dec_next = StBne;
`endif
      default:    op_legal = 1'b0;
    endcase
  end

  always_comb begin
    fn_legal = 1'b1;
    fn_alu   = 3'b010;
    case (Funct)
      6'b100000: fn_alu = 3'b010;
      6'b100010: fn_alu = 3'b110;
      6'b100100: fn_alu = 3'b000;
      6'b100101: fn_alu = 3'b001;
      6'b101010: fn_alu = 3'b111;
      default:   fn_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = mem_ready ? StDecode : StFetch;
      StDecode: state_d = dec_next;
      StMemadr: state_d = (Opcode == OpSw) ? StMemwr : StMemrd;
      StMemrd:  state_d = mem_ready ? StMemwb : (timeout ? StFetch : StMemrd);
      StMemwr:  state_d = (mem_ready || timeout) ? StFetch : StMemwr;
      StExec:   state_d = StAluwb;
      StAddiex: state_d = StAddiwb;
      default:  state_d = StFetch;
    endcase
  end

  // Counter only advances while a wait state is held, so it is zero on every entry
  always_comb begin
    cnt_d = '0;
    if (wait_st && !mem_ready && !timeout) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    Branch     = 1'b0;
    PCWrite    = 1'b0;
    illegal_op = 1'b0;
    mem_err    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    aluc       = 3'b000;
    take_br    = 1'b0;
    case (state_q)
      StFetch: begin
        ALUSrcB = 2'b01;
        aluc    = 3'b010;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        mem_err = timeout;
      end
      StDecode: begin
        ALUSrcB    = 2'b11;
        aluc       = 3'b010;
        illegal_op = !op_legal;
      end
      StMemadr, StAddiex: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        aluc    = 3'b010;
      end
      StMemrd: begin
        IorD    = 1'b1;
        mem_err = timeout;
      end
      StMemwr: begin
        IorD     = 1'b1;
        MemWrite = !timeout;
        mem_err  = timeout;
      end
      StMemwb: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      StExec: begin
        ALUSrcA    = 1'b1;
        aluc       = fn_alu;
        illegal_op = !fn_legal;
      end
      StAluwb: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      StBeq: begin
        ALUSrcA = 1'b1;
        aluc    = 3'b110;
        Branch  = 1'b1;
        PCSrc   = 2'b01;
        take_br = Zero;
      end
`ifdef MCU_BNE_EN
      StBne: begin
        ALUSrcA = 1'b1;
        aluc    = 3'b110;
        Branch  = 1'b1;
        PCSrc   = 2'b01;
        take_br = !Zero;
      end
`endif
      StAddiwb: RegWrite = 1'b1;
      StJump: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    PCEn = PCWrite | (Branch & take_br);
    // State already reads FETCH in reset; keep its strobes quiet too
    if (!rst_n) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCEn     = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
    ALUControl = ALUCTRL_W'(aluc);
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench: instruction-level step model vs. multicycle_control_unit.
module tb_multicycle_control_unit;

  localparam int unsigned To = 3;
  localparam int unsigned Aw = 4;

  localparam int StFetch = 0, StDecode = 1, StMemadr = 2, StMemrd = 3, StMemwb = 4;
  localparam int StMemwr = 5, StExec = 6, StAluwb = 7, StBeq = 8, StAddiex = 9;
  localparam int StAddiwb = 10, StJump = 11, StBne = 12;

  localparam logic [5:0] OpLw = 6'b100011, OpSw = 6'b101011, OpR = 6'b000000;
  localparam logic [5:0] OpBeq = 6'b000100, OpAddi = 6'b001000, OpJ = 6'b000010;
  localparam logic [5:0] OpBne = 6'b000101;

  logic clk, rst_n;
  logic [5:0] Opcode, Funct;
  logic Zero, mem_ready;
  logic IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, Branch;
  logic PCWrite, PCEn, illegal_op, mem_err;
  logic [1:0] ALUSrcB, PCSrc;
  logic [Aw-1:0] ALUControl;
  logic [3:0] state;
  logic [19:0] outv;

  int checks = 0;
  int errors = 0;

  multicycle_control_unit #(.TIMEOUT(To), .ALUCTRL_W(Aw)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Opcode     (Opcode),
    .Funct      (Funct),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .IorD       (IorD),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .ALUSrcA    (ALUSrcA),
    .Branch     (Branch),
    .PCWrite    (PCWrite),
    .PCEn       (PCEn),
    .illegal_op (illegal_op),
    .mem_err    (mem_err),
    .ALUSrcB    (ALUSrcB),
    .PCSrc      (PCSrc),
    .ALUControl (ALUControl),
    .state      (state)
  );

  assign outv = {IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, Branch,
                 PCWrite, PCEn, illegal_op, mem_err, ALUSrcB, PCSrc, ALUControl};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit op_known(input logic [5:0] op);
    bit k;
    k = (op == OpLw) || (op == OpSw) || (op == OpR) || (op == OpBeq) || (op == OpAddi) ||
        (op == OpJ);
`ifdef MCU_BNE_EN
    k = k || (op == OpBne);
`endif
    return k;
  endfunction

  // Expected outputs for one cycle, straight from the per-state output table
  function automatic logic [19:0] exp_outs(input int st, input logic [5:0] op,
                                           input logic [5:0] fn, input logic z,
                                           input logic mr, input logic to);
    logic iord, memw, irw, regw, regdst, m2r, srca, br, pcw, pcen, ill, merr;
    logic [1:0] srcb, pcsrc;
    logic [3:0] alu;
    {iord, memw, irw, regw, regdst, m2r, srca, br, pcw, pcen, ill, merr} = '0;
    srcb = 2'b00;
    pcsrc = 2'b00;
    alu = 4'b0000;
    case (st)
      StFetch: begin srcb = 2'b01; alu = 4'b0010; irw = mr; pcw = mr; pcen = mr; merr = to; end
      StDecode: begin srcb = 2'b11; alu = 4'b0010; ill = !op_known(op); end
      StMemadr, StAddiex: begin srca = 1'b1; srcb = 2'b10; alu = 4'b0010; end
      StMemrd: begin iord = 1'b1; merr = to; end
      StMemwr: begin iord = 1'b1; memw = !to; merr = to; end
      StMemwb: begin m2r = 1'b1; regw = 1'b1; end
      StExec: begin
        srca = 1'b1;
        case (fn)
          6'b100000: alu = 4'b0010;
          6'b100010: alu = 4'b0110;
          6'b100100: alu = 4'b0000;
          6'b100101: alu = 4'b0001;
          6'b101010: alu = 4'b0111;
          default: begin alu = 4'b0010; ill = 1'b1; end
        endcase
      end
      StAluwb: begin regdst = 1'b1; regw = 1'b1; end
      StBeq: begin srca = 1'b1; alu = 4'b0110; br = 1'b1; pcsrc = 2'b01; pcen = z; end
      StBne: begin srca = 1'b1; alu = 4'b0110; br = 1'b1; pcsrc = 2'b01; pcen = !z; end
      StAddiwb: regw = 1'b1;
      StJump: begin pcsrc = 2'b10; pcw = 1'b1; pcen = 1'b1; end
      default: ;
    endcase
    return {iord, memw, irw, regw, regdst, m2r, srca, br, pcw, pcen, ill, merr,
            srcb, pcsrc, alu};
  endfunction

  // Runs one instruction from FETCH. mem_ready rises after fetch_wait / mem_wait idle cycles
  // in the wait states; a wait longer than To ends the instruction with a timeout.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fetch_wait, input int mem_wait, input string name,
                           output int cycles);
    int q[$];
    int idx, st, w, lim;
    bit done, is_wait;
    logic mr, to;
    q = '{StFetch, StDecode};
    case (op)
      OpLw:   q = {q, StMemadr, StMemrd, StMemwb};
      OpSw:   q = {q, StMemadr, StMemwr};
      OpR:    q = {q, StExec, StAluwb};
      OpBeq:  q.push_back(StBeq);
      OpAddi: q = {q, StAddiex, StAddiwb};
      OpJ:    q.push_back(StJump);
`ifdef MCU_BNE_EN
      OpBne:  q.push_back(StBne);
`endif
      default: ;
    endcase
    Opcode = op;
    Funct = fn;
    Zero = z;
    cycles = 0;
    idx = 0;
    while (idx < q.size()) begin
      st = q[idx];
      w = 0;
      done = 1'b0;
      while (!done) begin
        is_wait = (st == StFetch) || (st == StMemrd) || (st == StMemwr);
        if (is_wait) begin
          lim = (st == StFetch) ? fetch_wait : mem_wait;
          mr = (w >= lim);
          to = !mr && (w == int'(To));
        end else begin
          mr = 1'($urandom_range(0, 1));
          to = 1'b0;
        end
        mem_ready = mr;
        #1;
        check_eq({name, "/state"}, 32'(state), 32'(st));
        check_eq({name, "/outs"}, 32'(outv), 32'(exp_outs(st, op, fn, z, mr, to)));
        @(negedge clk);
        cycles++;
        if (to) begin
          done = 1'b1;
          idx = q.size();
        end else if (is_wait && !mr) begin
          w++;
        end else begin
          done = 1'b1;
          idx++;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    Opcode = OpLw;
    #1;
    check_eq("rst/state", 32'(state), 32'(StFetch));
    check_eq("rst/wen", 32'({IRWrite, PCWrite, PCEn, MemWrite, RegWrite}), 32'd0);
    repeat (2) @(negedge clk);
    check_eq("rst/state_held", 32'(state), 32'(StFetch));
    rst_n = 1'b1;
  endtask

  logic [5:0] op_tbl[10] = '{OpLw, OpSw, OpR, OpBeq, OpAddi, OpJ, OpBne,
                             6'b111111, 6'b001101, OpR};
  logic [5:0] fn_tbl[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                            6'b000011};

  initial begin
    int cyc;
    logic [5:0] op, fn;
    rst_n = 1'b0;
    Opcode = '0;
    Funct = '0;
    Zero = 1'b0;
    mem_ready = 1'b0;
    do_reset();

    run_instr(OpLw, 6'd0, 1'b0, 0, 0, "lw", cyc);
    check_eq("lw/len", 32'(cyc), 32'd5);
    run_instr(OpR, 6'b101010, 1'b0, 0, 0, "slt", cyc);
    check_eq("slt/len", 32'(cyc), 32'd4);
    run_instr(OpBeq, 6'd0, 1'b1, 0, 0, "beq_z1", cyc);
    run_instr(OpBeq, 6'd0, 1'b0, 0, 0, "beq_z0", cyc);
    run_instr(OpBne, 6'd0, 1'b0, 0, 0, "bne_z0", cyc);
    run_instr(OpBne, 6'd0, 1'b1, 0, 0, "bne_z1", cyc);
    run_instr(6'b111111, 6'd0, 1'b0, 0, 0, "illegal", cyc);
    check_eq("illegal/len", 32'(cyc), 32'd2);
    run_instr(OpSw, 6'd0, 1'b0, 0, To + 1, "sw_timeout", cyc);
    check_eq("sw_timeout/len", 32'(cyc), 32'(3 + To + 1));
    run_instr(OpSw, 6'd0, 1'b0, 0, To, "sw_late_ready", cyc);
    check_eq("sw_late_ready/len", 32'(cyc), 32'(3 + To + 1));
    run_instr(OpAddi, 6'd0, 1'b0, To + 1, 0, "fetch_timeout", cyc);
    check_eq("fetch_timeout/len", 32'(cyc), 32'(To + 1));
    run_instr(OpJ, 6'd0, 1'b0, 1, 0, "j", cyc);

    // Reset in MEMRD: must drop to FETCH before the next clock edge
    Opcode = OpLw;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("midrst/pre_state", 32'(state), 32'(StMemrd));
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst/async_state", 32'(state), 32'(StFetch));
    check_eq("midrst/wen", 32'({IRWrite, PCWrite, PCEn, MemWrite, RegWrite}), 32'd0);
    @(posedge clk);
    #1;
    check_eq("midrst/held_state", 32'(state), 32'(StFetch));
    check_eq("midrst/held_regw", 32'(RegWrite), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(OpAddi, 6'd0, 1'b0, 0, 0, "post_rst_addi", cyc);
    check_eq("post_rst_addi/len", 32'(cyc), 32'd4);

    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : op_tbl[$urandom_range(0, 9)];
      fn = fn_tbl[$urandom_range(0, 5)];
      run_instr(op, fn, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0) ? int'(To) + 1 : int'($urandom_range(0, 2)),
                int'($urandom_range(0, To + 1)), $sformatf("rnd%0d", i), cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum wait cycles for mem_ready in a memory state; legal range 1..255.
REQ-002 Parameter ALUCTRL_W, default 3: ALUControl width; the encodings below occupy bits [2:0], and upper bits SHALL be 0.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset, asynchronous assert, active low.
REQ-005 Opcode  input  6  instruction opcode, taken from the instruction register.
REQ-006 Funct  input  6  R-type function field.
REQ-007 Zero  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  memory handshake; 1 means the access completes this cycle.
REQ-009 Outputs, all 1 bit: IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, Branch, PCWrite, PCEn, illegal_op, mem_err.
REQ-010 Outputs, all 2 bits: ALUSrcB, PCSrc.
REQ-011 ALUControl  output  ALUCTRL_W  ALU operation.
REQ-012 state  output  4  current FSM state, for debug.

Function
REQ-013 Moore FSM, registered state, with these encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11, BNE=12. All outputs SHALL be decoded combinationally from state, Funct, Zero and mem_ready.
REQ-014 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00.
- Holds while mem_ready=0.
- When mem_ready=1, asserts IRWrite=1 and PCWrite=1 for that cycle and moves to DECODE.
REQ-015 DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=010. Next state by Opcode:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 (R-type) -> EXEC
- 000100 (beq) -> BEQ
- 001000 (addi) -> ADDIEX
- 000010 (j) -> JUMP
- any other opcode -> FETCH, with illegal_op=1 for exactly this cycle.
REQ-016 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=010. Next state is MEMRD for lw and MEMWR for sw.
REQ-017 MEMRD: IorD=1; moves to MEMWB on mem_ready=1.
REQ-018 MEMWR: IorD=1, MemWrite=1; moves to FETCH on mem_ready=1.
REQ-019 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; then FETCH.
REQ-020 EXEC: ALUSrcA=1, ALUSrcB=00. ALUControl is decoded from Funct:
- 100000 -> 010
- 100010 -> 110
- 100100 -> 000
- 100101 -> 001
- 101010 -> 111
- any other Funct -> 010, with illegal_op=1 for this cycle.
Next state is ALUWB.
REQ-021 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; then FETCH.
REQ-022 BEQ: ALUSrcA=1, ALUSrcB=00, ALUControl=110, Branch=1, PCSrc=01; then FETCH.
REQ-023 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=010; then ADDIWB.
REQ-024 ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; then FETCH.
REQ-025 JUMP: PCSrc=10, PCWrite=1; then FETCH.
REQ-026 PCEn = PCWrite | (Branch & Zero) in BEQ. In BNE, PCEn = PCWrite | (Branch & ~Zero).
REQ-027 Any output not listed for a state SHALL be 0. ALUSrcB, PCSrc and ALUControl not listed for a state SHALL be 0.
REQ-028 Timeout counter:
- Clears on entry to FETCH, MEMRD or MEMWR.
- Increments each cycle the FSM waits there with mem_ready=0.
- When the count reaches TIMEOUT with mem_ready still 0, mem_err=1 for that cycle and the next state is FETCH.
- In that cycle, IRWrite, PCWrite and MemWrite SHALL be 0.
REQ-029 The counter is sized $clog2(TIMEOUT+1) bits and SHALL NOT wrap.
REQ-030 If mem_ready=1 arrives in the same cycle the count reaches TIMEOUT, mem_ready wins: normal completion, mem_err=0.
REQ-031 Unused state encodings (13..15) SHALL go to FETCH on the next clock.

Reset
REQ-032 rst_n=0 asynchronously forces state to FETCH and the timeout counter to 0.
REQ-033 During reset, all write-enable outputs SHALL be 0: IRWrite, PCWrite, PCEn, MemWrite, RegWrite.
REQ-034 The first fetch begins on the first rising clk after rst_n deasserts.
REQ-035 Reset asserted mid-instruction SHALL abandon the instruction; no further write strobes are issued for it.

Configuration
REQ-036 Macro MCU_BNE_EN: when defined, DECODE sends Opcode 000101 to BNE. BNE drives the same outputs as BEQ, with the PCEn rule of REQ-026.
REQ-037 When MCU_BNE_EN is undefined, Opcode 000101 is illegal per REQ-015, and the BNE state is unused per REQ-031.

Verification
REQ-038 Reset, then lw with mem_ready=1 every cycle -> state sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-039 R-type with Funct=101010 -> EXEC drives ALUControl=111; ALUWB drives RegWrite=1 and RegDst=1; 4-cycle instruction.
REQ-040 beq with Zero=1 -> PCEn=1 in BEQ; with Zero=0 -> PCEn=0. With MCU_BNE_EN, Opcode 000101 and Zero=0 -> PCEn=1.
REQ-041 Opcode 111111 -> illegal_op pulses 1 cycle in DECODE, then state=0, with no RegWrite or MemWrite.
REQ-042 TIMEOUT=3, sw with mem_ready held 0 in MEMWR -> mem_err=1 on the 4th wait cycle, then FETCH, with no MemWrite completion; repeat with mem_ready=1 on that cycle -> mem_err=0.
REQ-043 rst_n pulsed low during MEMRD -> state=0 immediately, without waiting for clk; no RegWrite follows.
